// File: rtl/bp_update_queue_if.sv
// Bundle between the execute lanes, the update queue and the fetch1
// predictor tables. The master side is execute/fetch1, the slave side is
// the queue itself.
interface bp_update_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          pc_we_i;

    logic          req0_valid_i;
    logic [31:0]   req0_pc_i;
    logic [31:0]   req0_tgt_i;
    logic          req0_taken_i;
    logic          req0_btb_i;

    logic          req1_valid_i;
    logic [31:0]   req1_pc_i;
    logic [31:0]   req1_tgt_i;
    logic          req1_taken_i;
    logic          req1_btb_i;

    logic          ready_o;
    logic          update_pht_o;
    logic          update_btb_o;
    logic [31:0]   update_pc_o;
    logic [31:0]   update_tgt_o;
    logic          last_br_o;
    logic [CW-1:0] count_o;

    modport master (
        output pc_we_i,
        output req0_valid_i, req0_pc_i, req0_tgt_i, req0_taken_i, req0_btb_i,
        output req1_valid_i, req1_pc_i, req1_tgt_i, req1_taken_i, req1_btb_i,
        input  ready_o, update_pht_o, update_btb_o, update_pc_o,
        input  update_tgt_o, last_br_o, count_o
    );

    modport slave (
        input  pc_we_i,
        input  req0_valid_i, req0_pc_i, req0_tgt_i, req0_taken_i, req0_btb_i,
        input  req1_valid_i, req1_pc_i, req1_tgt_i, req1_taken_i, req1_btb_i,
        output ready_o, update_pht_o, update_btb_o, update_pc_o,
        output update_tgt_o, last_br_o, count_o
    );
endinterface

// File: rtl/bp_update_queue.sv
// Branch predictor update queue: accepts up to two resolved branches per
// cycle (lane 0 older than lane 1) and presents them one at a time, in
// program order, to the fetch1 BTB/PHT update port. The head is consumed
// only on cycles where the predictor write enable is high.
module bp_update_queue #(
    parameter int DEPTH = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    bp_update_queue_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    // ready means at least two free slots, i.e. count <= DEPTH-2
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        taken;
        logic        btb;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          ready;
    logic          push0, push1, pop;
    logic [1:0]    n_push;
    logic          wr_a_en, wr_b_en;
    logic [PW-1:0] wr_a_idx, wr_b_idx;
    entry_t        wr_a_data, wr_b_data;
    entry_t        lane0, lane1, head_ent;
    logic          nonempty;

    assign lane0 = '{pc: bus.req0_pc_i, tgt: bus.req0_tgt_i,
                     taken: bus.req0_taken_i, btb: bus.req0_btb_i};
    assign lane1 = '{pc: bus.req1_pc_i, tgt: bus.req1_tgt_i,
                     taken: bus.req1_taken_i, btb: bus.req1_btb_i};

    // Accept/pop decisions and next-state pointer/count arithmetic.
    always_comb begin
        ready     = (count_q <= READY_MAX);
        nonempty  = (count_q != '0);
        push0     = ready && bus.req0_valid_i;
        push1     = ready && bus.req1_valid_i;
        pop       = bus.pc_we_i && nonempty;
        n_push    = {1'b0, push0} + {1'b0, push1};

        // Slot A is the tail: lane 0 if present, otherwise a lone lane 1.
        // Slot B (tail+1) is only used when both lanes arrive together.
        wr_a_en   = push0 || push1;
        wr_a_idx  = tail_q;
        wr_a_data = push0 ? lane0 : lane1;
        wr_b_en   = push0 && push1;
        wr_b_idx  = tail_q + PW'(1);
        wr_b_data = lane1;

        tail_d    = tail_q + PW'(n_push);
        head_d    = head_q + PW'(pop);
        count_d   = count_q + CW'(n_push) - CW'(pop);
    end

    // Pointer and occupancy registers; reset discards anything pending.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is not reset; stale contents are unreachable once the
    // pointers are cleared.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            if (wr_a_en) mem_q[wr_a_idx] <= wr_a_data;
            if (wr_b_en) mem_q[wr_b_idx] <= wr_b_data;
        end
    end

    // Head presentation, forced to zero when nothing is queued.
    always_comb begin
        head_ent         = mem_q[head_q];
        bus.ready_o      = ready;
        bus.count_o      = count_q;
        bus.update_pht_o = nonempty;
        bus.update_btb_o = nonempty && head_ent.btb;
        bus.update_pc_o  = nonempty ? head_ent.pc    : 32'h0;
        bus.update_tgt_o = nonempty ? head_ent.tgt   : 32'h0;
        bus.last_br_o    = nonempty && head_ent.taken;
    end
endmodule

// File: tb/tb_bp_update_queue.sv
// Bench for bp_update_queue: directed scenarios followed by random traffic.
// A queue of expected entries is filled when the bench's own model accepts
// requests; a negedge monitor compares the presented head against it.
module tb_bp_update_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        taken;
        logic        btb;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bp_update_queue_if #(.DEPTH(DEPTH)) bus ();

    bp_update_queue #(.DEPTH(DEPTH)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    ent_t exp_q[$];
    int   occ      = 0;
    bit   last_acc = 1'b0;
    bit   mon_en   = 1'b0;
    int   n_chk    = 0;
    int   n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set0(input bit v, input logic [31:0] pc, input logic [31:0] tgt,
                        input bit tk, input bit bt);
        bus.req0_valid_i = v; bus.req0_pc_i = pc; bus.req0_tgt_i = tgt;
        bus.req0_taken_i = tk; bus.req0_btb_i = bt;
    endtask

    task automatic set1(input bit v, input logic [31:0] pc, input logic [31:0] tgt,
                        input bit tk, input bit bt);
        bus.req1_valid_i = v; bus.req1_pc_i = pc; bus.req1_tgt_i = tgt;
        bus.req1_taken_i = tk; bus.req1_btb_i = bt;
    endtask

    // One clock: the reference model applies the rules to the inputs held
    // across the edge, then inputs may change 1ns later.
    task automatic tick();
        bit rdy;
        int np;
        bit pp;
        @(posedge clk);
        rdy = (DEPTH - occ) >= 2;
        if (rst) begin
            exp_q.delete();
            occ      = 0;
            last_acc = 1'b0;
        end else begin
            np = 0;
            if (rdy && bus.req0_valid_i) begin
                exp_q.push_back('{bus.req0_pc_i, bus.req0_tgt_i, bus.req0_taken_i, bus.req0_btb_i});
                np++;
            end
            if (rdy && bus.req1_valid_i) begin
                exp_q.push_back('{bus.req1_pc_i, bus.req1_tgt_i, bus.req1_taken_i, bus.req1_btb_i});
                np++;
            end
            pp       = bus.pc_we_i && (occ != 0);
            occ      = occ + np - int'(pp);
            last_acc = rdy;
        end
        #1;
    endtask

    task automatic drain();
        set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
        bus.pc_we_i = 1'b1;
        for (int g = 0; g < 3 * DEPTH && occ != 0; g++) tick();
        chk("drain_empty", bus.count_o, 0);
    endtask

    // Monitor: compares every presented head with the oldest expected entry
    // and retires it when the write enable will consume it at the next edge.
    always @(negedge clk) begin
        ent_t e;
        if (mon_en) begin
            chk("count", bus.count_o, occ);
            chk("ready", bus.ready_o, 32'((DEPTH - occ) >= 2));
            if (exp_q.size() == 0) begin
                chk("pht_empty", bus.update_pht_o, 0);
                chk("btb_empty", bus.update_btb_o, 0);
                chk("pc_empty",  bus.update_pc_o,  0);
                chk("tgt_empty", bus.update_tgt_o, 0);
                chk("br_empty",  bus.last_br_o,    0);
            end else begin
                e = exp_q[0];
                chk("pht",   bus.update_pht_o, 1);
                chk("btb",   bus.update_btb_o, e.btb);
                chk("pc",    bus.update_pc_o,  e.pc);
                chk("tgt",   bus.update_tgt_o, e.tgt);
                chk("taken", bus.last_br_o,    e.taken);
                if (bus.pc_we_i) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        bus.pc_we_i = 1'b0;
        set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        mon_en = 1'b1;
        chk("rst_ready", bus.ready_o, 1);
        chk("rst_pht", bus.update_pht_o, 0);
        chk("rst_count", bus.count_o, 0);

        // Single lane-0 update, drained the next cycle.
        set0(1, 32'h100, 32'h200, 1, 1);
        bus.pc_we_i = 1'b1;
        tick();
        set0(0, 0, 0, 0, 0);
        chk("t1_pht", bus.update_pht_o, 1);
        chk("t1_btb", bus.update_btb_o, 1);
        chk("t1_pc", bus.update_pc_o, 32'h100);
        chk("t1_tgt", bus.update_tgt_o, 32'h200);
        chk("t1_br", bus.last_br_o, 1);
        tick();
        chk("t1_cnt0", bus.count_o, 0);
        chk("t1_pc0", bus.update_pc_o, 0);

        // Dual push held at the head while pc_we is low, then ordered drain.
        bus.pc_we_i = 1'b0;
        set0(1, 32'h10, 32'h1010, 0, 0);
        set1(1, 32'h14, 32'h1014, 1, 1);
        tick();
        set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_hold_pc", bus.update_pc_o, 32'h10);
            chk("t2_hold_btb", bus.update_btb_o, 0);
            if (i < 2) tick();
        end
        bus.pc_we_i = 1'b1;
        tick();
        chk("t2_second_pc", bus.update_pc_o, 32'h14);
        chk("t2_second_btb", bus.update_btb_o, 1);
        tick();
        chk("t2_empty", bus.count_o, 0);

        // Lane 1 alone lands at the tail.
        bus.pc_we_i = 1'b0;
        set1(1, 32'h24, 32'h2024, 1, 0);
        tick();
        set1(0, 0, 0, 0, 0);
        chk("t3_cnt", bus.count_o, 1);
        chk("t3_pc", bus.update_pc_o, 32'h24);
        drain();

        // Fill under sustained dual traffic; the held pair enqueues later.
        bus.pc_we_i = 1'b0;
        set0(1, 32'h200, 32'h3200, 0, 1); set1(1, 32'h204, 32'h3204, 1, 0);
        tick();
        chk("t4_cnt2", bus.count_o, 2);
        chk("t4_rdy2", bus.ready_o, 1);
        set0(1, 32'h208, 32'h3208, 1, 1); set1(1, 32'h20c, 32'h320c, 0, 0);
        tick();
        chk("t4_cnt4", bus.count_o, 4);
        chk("t4_rdy4", bus.ready_o, 0);
        set0(1, 32'h210, 32'h3210, 1, 0); set1(1, 32'h214, 32'h3214, 1, 1);
        tick();
        chk("t4_full_hold", bus.count_o, 4);
        bus.pc_we_i = 1'b1;
        tick();
        chk("t4_pop1", bus.count_o, 3);
        chk("t4_rdy3", bus.ready_o, 0);
        tick();
        chk("t4_pop2", bus.count_o, 2);
        tick();
        chk("t4_held_in", bus.count_o, 3);
        drain();

        // Wrap: alternate single push / pop until tail sits at DEPTH-1,
        // then a dual push straddles the end of the buffer.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.pc_we_i = 1'b0;
            set0(1, 32'h300 + 32'(4 * i), 32'h5300 + 32'(i), i[0], ~i[0]);
            tick();
            set0(0, 0, 0, 0, 0);
            bus.pc_we_i = 1'b1;
            tick();
        end
        bus.pc_we_i = 1'b0;
        set0(1, 32'h400, 32'h6400, 1, 0); set1(1, 32'h404, 32'h6404, 0, 1);
        tick();
        set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
        chk("t5_cnt", bus.count_o, 2);
        chk("t5_first", bus.update_pc_o, 32'h400);
        bus.pc_we_i = 1'b1;
        tick();
        chk("t5_second", bus.update_pc_o, 32'h404);
        tick();

        // Reset with three pending and a dual push in the same cycle.
        bus.pc_we_i = 1'b0;
        set0(1, 32'h500, 32'h7500, 1, 1); set1(1, 32'h504, 32'h7504, 1, 1);
        tick();
        set1(0, 0, 0, 0, 0);
        set0(1, 32'h508, 32'h7508, 0, 1);
        tick();
        chk("t6_cnt3", bus.count_o, 3);
        set1(1, 32'h50c, 32'h750c, 1, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
        chk("t6_cnt", bus.count_o, 0);
        chk("t6_pht", bus.update_pht_o, 0);
        chk("t6_rdy", bus.ready_o, 1);

        // Random traffic; unaccepted requests are held unchanged.
        for (int c = 0; c < 3000; c++) begin
            bit hold;
            hold = !last_acc && (bus.req0_valid_i || bus.req1_valid_i);
            if (!hold) begin
                set0($urandom_range(0, 2) != 0, $urandom, $urandom,
                     1'($urandom), 1'($urandom));
                set1($urandom_range(0, 1) != 0, $urandom, $urandom,
                     1'($urandom), 1'($urandom));
            end
            bus.pc_we_i = $urandom_range(0, 3) != 0;
            rst = ($urandom_range(0, 199) == 0);
            tick();
            rst = 1'b0;
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
